// File: rtl/write_txn_ctrl.sv
// Write-path address decoder and handshake sequencer: routes one AW/W/B write at a time
// to one of five slaves selected by addr[15:12], or answers with DECERR on a decode miss.
module write_txn_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic        m_wvalid,
    output logic        m_wready,
    input  logic        m_bready,
    output logic [4:0]  s_awvalid,
    input  logic [4:0]  s_awready,
    output logic [4:0]  s_wvalid,
    input  logic [4:0]  s_wready,
    input  logic        rt_bvalid,
    output logic        rt_bready,
    output logic [2:0]  aw_sel_q,
    output logic        err_bvalid,
    output logic [1:0]  err_bresp,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_sel;
    logic        r_dec_err;

    logic [3:0]  w_nib;
    logic        w_hit;
    logic [4:0]  w_sel_dec;
    logic        w_in_aw;
    logic        w_in_w;
    logic        w_in_b;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_unused_addr;

    assign w_nib         = m_awaddr[15:12];
    assign w_hit         = (w_nib <= 4'd4);
    assign w_unused_addr = ^{m_awaddr[31:16], m_awaddr[11:0]};

    // One-hot decode of the captured slave index; index is always 0..4.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sel_dec
            assign w_sel_dec[gi] = (r_sel == 3'(gi));
        end
    endgenerate

    assign w_in_aw = (r_state == ST_AW);
    assign w_in_w  = (r_state == ST_W);
    assign w_in_b  = (r_state == ST_B);

    // Master-side handshakes pass straight through to the selected slave.
    assign s_awvalid  = (w_in_aw && !r_dec_err && m_awvalid) ? w_sel_dec : 5'd0;
    assign m_awready  = w_in_aw && (r_dec_err || (|(s_awready & w_sel_dec)));
    assign s_wvalid   = (w_in_w && !r_dec_err && m_wvalid) ? w_sel_dec : 5'd0;
    assign m_wready   = w_in_w && (r_dec_err || (|(s_wready & w_sel_dec)));
    assign rt_bready  = w_in_b && !r_dec_err && m_bready;
    assign err_bvalid = w_in_b && r_dec_err;
    assign err_bresp  = (w_in_b && r_dec_err) ? 2'b11 : 2'b00;
    assign aw_sel_q   = r_sel;
    assign busy       = (r_state != ST_IDLE);

    assign w_aw_hs = m_awvalid && m_awready;
    assign w_w_hs  = m_wvalid && m_wready;
    assign w_b_hs  = m_bready && (r_dec_err || rt_bvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= 3'd0;
            r_dec_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Selection is only ever loaded here, so it holds for the whole write.
                    if (m_awvalid) begin
                        r_sel     <= w_hit ? w_nib[2:0] : 3'd0;
                        r_dec_err <= !w_hit;
                        r_state   <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (w_aw_hs) begin
                        r_state <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_w_hs) begin
                        r_state <= ST_B;
                    end
                end
                ST_B: begin
                    if (w_b_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_txn_ctrl.sv
// Randomized bench for write_txn_ctrl: driver issues writes and queues the expected
// routing/response, a negedge monitor checks DUT outputs against the queue head.
module tb_write_txn_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_bready;
    logic [4:0]  s_awvalid;
    logic [4:0]  s_awready;
    logic [4:0]  s_wvalid;
    logic [4:0]  s_wready;
    logic        rt_bvalid;
    logic        rt_bready;
    logic [2:0]  aw_sel_q;
    logic        err_bvalid;
    logic [1:0]  err_bresp;
    logic        busy;

    write_txn_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .m_awaddr   (m_awaddr),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_bready   (m_bready),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .rt_bvalid  (rt_bvalid),
        .rt_bready  (rt_bready),
        .aw_sel_q   (aw_sel_q),
        .err_bvalid (err_bvalid),
        .err_bresp  (err_bresp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        bit         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_issued  = 0;
    int   n_done    = 0;
    int   aw_delay  = 0;
    int   w_delay   = 0;
    bit   rt_always = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({m_awready, m_wready, s_awvalid, s_wvalid, rt_bready, err_bvalid, err_bresp, busy});
    endfunction

    // Slave side: the addressed slave grants after a programmable number of cycles;
    // unaddressed ready bits toggle randomly and must be ignored by the DUT.
    initial begin
        int   aw_cnt = 0;
        int   w_cnt  = 0;
        logic [4:0] r5;
        s_awready = 5'd0;
        s_wready  = 5'd0;
        rt_bvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            r5 = 5'($urandom);
            if (s_awvalid != 5'd0) begin
                s_awready = (aw_cnt >= aw_delay) ? (r5 | s_awvalid) : (r5 & ~s_awvalid);
                aw_cnt++;
            end else begin
                aw_cnt    = 0;
                s_awready = r5;
            end
            r5 = 5'($urandom);
            if (s_wvalid != 5'd0) begin
                s_wready = (w_cnt >= w_delay) ? (r5 | s_wvalid) : (r5 & ~s_wvalid);
                w_cnt++;
            end else begin
                w_cnt    = 0;
                s_wready = r5;
            end
            rt_bvalid = rt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: phase advances only on observed handshakes of the queued write.
    initial begin
        int         phase = 0;
        exp_t       e;
        logic [4:0] onehot;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", all_outs(), 32'd0);
                chk("rst_sel", 32'(aw_sel_q), 32'd0);
                phase = 0;
                exp_q.delete();
                continue;
            end
            chk("onehot", 32'(($countones(s_awvalid) <= 1) && ($countones(s_wvalid) <= 1)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("idle_outputs", all_outs(), 32'd0);
                continue;
            end
            e      = exp_q[0];
            onehot = e.err ? 5'd0 : (5'd1 << e.sel);
            case (phase)
                0: begin
                    chk("w_held_off", 32'({m_wready, s_wvalid}), 32'd0);
                    chk("b_quiet_aw", 32'({rt_bready, err_bvalid, err_bresp}), 32'd0);
                    if (!busy) begin
                        chk("capture_cycle", 32'({m_awready, s_awvalid}), 32'd0);
                    end else begin
                        chk("aw_sel_q", 32'(aw_sel_q), 32'(e.sel));
                        chk("s_awvalid", 32'(s_awvalid), 32'(m_awvalid ? onehot : 5'd0));
                        chk("m_awready", 32'(m_awready), 32'(e.err ? 1'b1 : s_awready[e.sel]));
                        if (m_awvalid && m_awready) phase = 1;
                    end
                end
                1: begin
                    chk("busy_w", 32'(busy), 32'd1);
                    chk("aw_quiet_w", 32'({m_awready, s_awvalid}), 32'd0);
                    chk("aw_sel_q", 32'(aw_sel_q), 32'(e.sel));
                    chk("s_wvalid", 32'(s_wvalid), 32'(m_wvalid ? onehot : 5'd0));
                    chk("m_wready", 32'(m_wready), 32'(e.err ? 1'b1 : s_wready[e.sel]));
                    chk("b_quiet_w", 32'({rt_bready, err_bvalid, err_bresp}), 32'd0);
                    if (m_wvalid && m_wready) phase = 2;
                end
                default: begin
                    chk("busy_b", 32'(busy), 32'd1);
                    chk("aw_w_quiet_b", 32'({m_awready, s_awvalid, m_wready, s_wvalid}), 32'd0);
                    chk("aw_sel_q", 32'(aw_sel_q), 32'(e.sel));
                    chk("err_bvalid", 32'(err_bvalid), 32'(e.err));
                    chk("err_bresp", 32'(err_bresp), e.err ? 32'd3 : 32'd0);
                    chk("rt_bready", 32'(rt_bready), 32'(!e.err && m_bready));
                    if (m_bready && (e.err || rt_bvalid)) begin
                        void'(exp_q.pop_front());
                        phase = 0;
                        n_done++;
                    end
                end
            endcase
        end
    end

    // Waits for a master-side handshake condition, then steps past the clock edge.
    task automatic wait_hs(input int which, output bit ok);
        int  n = 0;
        bit  c;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            case (which)
                0:       c = m_awready;
                1:       c = m_wready;
                default: c = err_bvalid || (rt_bready && rt_bvalid);
            endcase
            if (c) break;
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL handshake_timeout: channel %0d no ready after %0d cycles", which, n);
                ok = 1'b0;
                rst = 1'b1;
                m_awvalid = 1'b0;
                m_wvalid  = 1'b0;
                m_bready  = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int aw_d, input int w_d,
                            input int bwait, input bit early_w, input bit rt_al);
        exp_t e;
        bit   ok;
        aw_delay  = aw_d;
        w_delay   = w_d;
        rt_always = rt_al;
        if (early_w) begin
            m_wvalid = 1'b1;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
        m_awaddr  = addr;
        m_awvalid = 1'b1;
        e.err = (addr[15:12] > 4'd4);
        e.sel = e.err ? 3'd0 : addr[14:12];
        exp_q.push_back(e);
        n_issued++;
        wait_hs(0, ok);
        if (!ok) return;
        m_awvalid = 1'b0;
        m_awaddr  = $urandom;
        m_wvalid  = 1'b1;
        wait_hs(1, ok);
        if (!ok) return;
        m_wvalid = 1'b0;
        repeat (bwait) begin
            @(posedge clk);
            #1;
        end
        m_bready = 1'b1;
        wait_hs(2, ok);
        m_bready = 1'b0;
        $display("txn addr=0x%08h sel=%0d decerr=%0b done=%0d", addr, e.sel, e.err, n_done);
    endtask

    initial begin
        bit          ok;
        logic [31:0] addr;
        rst       = 1'b1;
        m_awaddr  = 32'd0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_write(32'h0000_3000, 0, 0, 0, 1'b0, 1'b1);
        do_write(32'h0000_7000, 0, 0, 2, 1'b0, 1'b1);
        do_write(32'h0000_1000, 3, 0, 2, 1'b0, 1'b1);
        do_write(32'h0000_2000, 0, 0, 0, 1'b1, 1'b1);

        // Abandon a write that is parked in W by asserting reset between clock edges.
        w_delay   = 1000;
        m_awaddr  = 32'h0000_2000;
        m_awvalid = 1'b1;
        exp_q.push_back('{sel: 3'd2, err: 1'b0});
        wait_hs(0, ok);
        m_awvalid = 1'b0;
        m_wvalid  = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", all_outs(), 32'd0);
        m_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("txn reset abandoned write to slave 2");
        do_write(32'h0000_4000, 0, 0, 0, 1'b0, 1'b1);

        do_write(32'h0000_0000, 0, 0, 0, 1'b0, 1'b1);
        do_write(32'h0000_2000, 0, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            addr = $urandom;
            addr[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            do_write(addr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("txn_count", 32'(n_done), 32'(n_issued));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
